ysyx_22050854_csr_file: RTL and testbench

//  Parametrised machine-mode CSR file for the NPC core, sitting between the EXU/WBU and the

---
 rtl/ysyx_22050854_csr_file_pkg.sv | 26 ++
 rtl/ysyx_22050854_csr_counter.sv | 26 ++
 rtl/ysyx_22050854_csr_file.sv | 150 +++++++++++++++
 tb/tb_ysyx_22050854_csr_file.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050854_csr_file_pkg.sv
// Shared CSR constants for the NPC machine-mode CSR file: addresses, op encodings,
// mstatus layout and reset value.
package ysyx_22050854_csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

    localparam int MST_MIE  = 3;
    localparam int MST_MPIE = 7;

    // SXL/UXL = 2 (64-bit) and MPP = 11; the low 32 bits are the RV32 reset value.
    localparam logic [63:0] MSTATUS_RST64  = 64'hA_0000_1800;
    localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;

endpackage

// File: rtl/ysyx_22050854_csr_counter.sv
// Free-running counter with a load port that takes precedence over the increment.
module ysyx_22050854_csr_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)     cnt_d = load_val_i;
        else if (inc_i) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/ysyx_22050854_csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write, single-cycle trap entry / mret,
// and the mcycle counter. Reads are combinational and always return pre-cycle state.
module ysyx_22050854_csr_file
    import ysyx_22050854_csr_file_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int IALIGN     = 4,
    parameter bit CYCLE_EN   = 1'b1,
    parameter bit SCRATCH_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_src_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret_valid,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mret_target,
    output logic            mie_out
);
    localparam int              ALB       = $clog2(IALIGN);
    localparam logic [XLEN-1:0] MST_RST   = MSTATUS_RST64[XLEN-1:0];
    localparam logic [XLEN-1:0] EPC_MASK  = {XLEN{1'b1}} << ALB;
    localparam logic [XLEN-1:0] TVEC_MASK = {XLEN{1'b1}} << 2;

    csr_op_e         op;
    logic            sel_mstatus, sel_mtvec, sel_mepc, sel_mcause, sel_mscratch, sel_mcycle;
    logic            sel_any, wr_en;
    logic [XLEN-1:0] old_val, new_val, mstatus_val, mscratch_val, mcycle_val;

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;

    assign op = csr_op_e'(csr_op);

    assign sel_mstatus  = (csr_addr == CSR_MSTATUS);
    assign sel_mtvec    = (csr_addr == CSR_MTVEC);
    assign sel_mepc     = (csr_addr == CSR_MEPC);
    assign sel_mcause   = (csr_addr == CSR_MCAUSE);
    assign sel_mscratch = SCRATCH_EN && (csr_addr == CSR_MSCRATCH);
    assign sel_mcycle   = CYCLE_EN && (csr_addr == CSR_MCYCLE);
    assign sel_any      = sel_mstatus | sel_mtvec | sel_mepc | sel_mcause | sel_mscratch | sel_mcycle;
    assign csr_illegal  = (op != CSR_NONE) && !sel_any;

    // Only MIE/MPIE are state; MPP and the XL fields live in the constant.
    assign mstatus_val = MST_RST | (XLEN'(mpie_q) << MST_MPIE) | (XLEN'(mie_q) << MST_MIE);

    always_comb begin
        old_val = '0;
        if (sel_mstatus)  old_val = mstatus_val;
        if (sel_mtvec)    old_val = mtvec_q;
        if (sel_mepc)     old_val = mepc_q;
        if (sel_mcause)   old_val = mcause_q;
        if (sel_mscratch) old_val = mscratch_val;
        if (sel_mcycle)   old_val = mcycle_val;
    end

    always_comb begin
        new_val = old_val;
        case (op)
            CSR_RW:  new_val = csr_wdata;
            CSR_RS:  new_val = old_val | csr_wdata;
            CSR_RC:  new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    // A trap or mret in the same cycle suppresses the CSR write everywhere, mcycle included.
    assign wr_en = (op != CSR_NONE) && sel_any && (op == CSR_RW || !csr_src_zero)
                   && !trap_valid && !mret_valid;

    assign csr_rdata = old_val;

    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (trap_valid) begin
            mepc_d   = trap_pc & EPC_MASK;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_en) begin
            if (sel_mstatus) begin
                mie_d  = new_val[MST_MIE];
                mpie_d = new_val[MST_MPIE];
            end
            if (sel_mtvec)  mtvec_d  = new_val & TVEC_MASK;
            if (sel_mepc)   mepc_d   = new_val & EPC_MASK;
            if (sel_mcause) mcause_d = new_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    generate
        if (SCRATCH_EN) begin : g_scratch
            logic [XLEN-1:0] mscratch_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                    mscratch_q <= '0;
                else if (wr_en && sel_mscratch) mscratch_q <= new_val;
            end
            assign mscratch_val = mscratch_q;
        end else begin : g_no_scratch
            assign mscratch_val = '0;
        end

        if (CYCLE_EN) begin : g_cycle
            ysyx_22050854_csr_counter #(.W(XLEN)) u_mcycle (
                .clk        (clk),
                .rst_n      (rst_n),
                .inc_i      (1'b1),
                .load_i     (wr_en && sel_mcycle),
                .load_val_i (new_val),
                .cnt_o      (mcycle_val)
            );
        end else begin : g_no_cycle
            assign mcycle_val = '0;
        end
    endgenerate

    assign trap_vector = mtvec_q;
    assign mret_target = mepc_q;
    assign mie_out     = mie_q;
endmodule

// File: tb/tb_ysyx_22050854_csr_file.sv
// Bench for the CSR file: directed literal checks plus randomized traffic, all compared
// every cycle against a value-level model of the architectural CSR state.
module tb_ysyx_22050854_csr_file;
    import ysyx_22050854_csr_file_pkg::*;

    localparam logic [63:0] MST0 = 64'hA_0000_1800;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h300;
    logic [63:0] csr_wdata = '0;
    logic        csr_src_zero = 1'b0;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0, trap_cause = '0;
    logic        mret_valid = 1'b0;
    logic [63:0] trap_vector, mret_target;
    logic        mie_out;

    int n_cmp = 0, n_err = 0;
    bit started = 1'b0;

    ysyx_22050854_csr_file dut (
        .clk(clk), .rst_n(rst_n), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .trap_valid(trap_valid), .trap_pc(trap_pc),
        .trap_cause(trap_cause), .mret_valid(mret_valid), .trap_vector(trap_vector),
        .mret_target(mret_target), .mie_out(mie_out)
    );

    always #5 clk = ~clk;

    // Architectural model: whole-register values, no knowledge of the RTL's split state.
    logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mscratch, m_mcycle;

    function automatic bit is_csr(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00};
    endfunction

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_mcycle;
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] wval(input logic [1:0] op, input logic [63:0] o, input logic [63:0] w);
        case (op)
            2'b01:   return w;
            2'b10:   return o | w;
            default: return o & ~w;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mstatus <= MST0; m_mtvec <= '0; m_mepc <= '0;
            m_mcause <= '0; m_mscratch <= '0; m_mcycle <= '0;
        end else begin
            m_mcycle <= m_mcycle + 64'd1;
            if (trap_valid) begin
                m_mepc    <= trap_pc & ~64'h3;
                m_mcause  <= trap_cause;
                m_mstatus <= MST0 | (m_mstatus[3] ? 64'h80 : 64'h0);
            end else if (mret_valid) begin
                m_mstatus <= MST0 | 64'h80 | (m_mstatus[7] ? 64'h8 : 64'h0);
            end else if (csr_op != 2'b00 && is_csr(csr_addr) && (csr_op == 2'b01 || !csr_src_zero)) begin
                case (csr_addr)
                    12'h300: m_mstatus  <= MST0 | (wval(csr_op, m_read(csr_addr), csr_wdata) & 64'h88);
                    12'h305: m_mtvec    <= wval(csr_op, m_read(csr_addr), csr_wdata) & ~64'h3;
                    12'h340: m_mscratch <= wval(csr_op, m_read(csr_addr), csr_wdata);
                    12'h341: m_mepc     <= wval(csr_op, m_read(csr_addr), csr_wdata) & ~64'h3;
                    12'h342: m_mcause   <= wval(csr_op, m_read(csr_addr), csr_wdata);
                    default: m_mcycle   <= wval(csr_op, m_read(csr_addr), csr_wdata);
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("rdata", csr_rdata, m_read(csr_addr));
            check("illegal", 64'(csr_illegal), 64'(csr_op != 2'b00 && !is_csr(csr_addr)));
            check("trap_vector", trap_vector, m_mtvec);
            check("mret_target", mret_target, m_mepc);
            check("mie_out", 64'(mie_out), 64'(m_mstatus[3]));
        end
    end

    task automatic step(input logic [1:0] op, input logic [11:0] a, input logic [63:0] w,
                        input bit sz = 1'b0, input bit tv = 1'b0, input logic [63:0] pc = '0,
                        input logic [63:0] cause = '0, input bit mr = 1'b0);
        @(posedge clk); #1;
        csr_op = op; csr_addr = a; csr_wdata = w; csr_src_zero = sz;
        trap_valid = tv; trap_pc = pc; trap_cause = cause; mret_valid = mr;
        #1;
    endtask

    logic [11:0] addrs [8];

    initial begin
        @(posedge clk); #1;
        started = 1'b1;
        check("rst mstatus", csr_rdata, MST0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        step(2'b01, 12'h305, 64'h8000_0103);
        check("mtvec old", csr_rdata, 64'h0);
        step(2'b00, 12'h305, 64'h0);
        check("mtvec new", csr_rdata, 64'h8000_0100);
        check("trap_vector lit", trap_vector, 64'h8000_0100);

        step(2'b10, 12'h300, 64'h8);
        check("rs old", csr_rdata, MST0);
        step(2'b10, 12'h300, 64'h8, 1'b1);
        check("rs mie", csr_rdata, MST0 | 64'h8);
        check("mie_out set", 64'(mie_out), 64'h1);
        step(2'b11, 12'h300, 64'h8);
        check("rs srczero", csr_rdata, MST0 | 64'h8);
        step(2'b10, 12'h300, 64'h8);
        check("rc mie", csr_rdata, MST0);
        step(2'b01, 12'h300, 64'h0);
        step(2'b00, 12'h300, 64'h0);
        check("rw0 mpp", csr_rdata, MST0);

        step(2'b10, 12'h300, 64'h8);
        step(2'b00, 12'h000, 64'h0, 1'b0, 1'b1, 64'h8000_0010, MCAUSE_ECALL_M);
        step(2'b00, 12'h342, 64'h0);
        check("ecall mcause", csr_rdata, 64'd11);
        check("ecall mepc", mret_target, 64'h8000_0010);
        step(2'b00, 12'h300, 64'h0, 1'b0, 1'b0, '0, '0, 1'b1);
        check("trap mstatus", csr_rdata, MST0 | 64'h80);
        step(2'b00, 12'h300, 64'h0);
        check("mret mstatus", csr_rdata, MST0 | 64'h88);
        check("mret mie_out", 64'(mie_out), 64'h1);

        step(2'b01, 12'h340, 64'h11);
        step(2'b01, 12'h340, 64'h55, 1'b0, 1'b1, 64'h8000_0022, 64'd2);
        step(2'b00, 12'h340, 64'h0);
        check("collide scratch", csr_rdata, 64'h11);
        check("collide mepc", mret_target, 64'h8000_0020);

        step(2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
        step(2'b00, 12'hB00, 64'h0);
        check("mcycle fe", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
        step(2'b00, 12'hB00, 64'h0);
        check("mcycle ff", csr_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        step(2'b00, 12'hB00, 64'h0);
        check("mcycle wrap", csr_rdata, 64'h0);

        step(2'b01, 12'h7C0, 64'h1234);
        check("illegal flag", 64'(csr_illegal), 64'h1);
        check("illegal rdata", csr_rdata, 64'h0);
        step(2'b00, 12'h342, 64'h0);
        check("illegal nochg", csr_rdata, 64'd2);

        for (int i = 0; i < 3000; i++) begin
            addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'h7C0, 12'($urandom)};
            step(2'($urandom), addrs[$urandom_range(0, 7)], {$urandom, $urandom},
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, {$urandom, $urandom},
                 {$urandom, $urandom}, $urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
        end

        @(posedge clk); #1;
        rst_n = 1'b1;
        csr_op = 2'b00; trap_valid = 1'b0; mret_valid = 1'b0; csr_addr = 12'h300;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst mstatus", csr_rdata, MST0);
        check("midrst tvec", trap_vector, 64'h0);
        check("midrst mepc", mret_target, 64'h0);
        check("midrst mie", 64'(mie_out), 64'h0);
        csr_addr = 12'h342; #1;
        check("midrst mcause", csr_rdata, 64'h0);
        @(posedge clk); #1;
        csr_addr = 12'hB00; #1;
        check("midrst mcycle", csr_rdata, 64'h0);
        rst_n = 1'b1;
        step(2'b00, 12'hB00, 64'h0);
        check("mcycle after rst", csr_rdata, 64'h1);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
